zfoblock_sprite_fetch: RTL
==========================

// Module: zfoblock_sprite_fetch
// PURPOSE
// Upstream stage of the zfoblock palette lookup. Maps the current raster position (DrawX/DrawY)
// to a sprite-ROM address, then returns the 4-bit palette index plus a hit flag to the palette
// stage. Handles horizontal flip (fighter facing), an N-frame one-shot animation, and
// frame-synchronous latching of position/flip so a sprite never tears mid-frame.
// PARAMETERS
// SPR_W        64     sprite width in pixels (power of two)
// SPR_H        64     sprite height in pixels (power of two)
// FRAMES       4      animation frames stored back-to-back in the ROM (power of two)
// ADDR_W       14     ROM address width; must equal log2(SPR_W*SPR_H*FRAMES)
// FRAME_TICKS  6      frame_start pulses per animation frame (>=1)
// TRANSP_IDX   4'h0   palette index treated as transparent
// PORTS
// Clk          in   1       pixel-domain clock
// Reset_n      in   1       synchronous reset, active-low
// frame_start  in   1       1-cycle pulse at start of vertical blank
// pix_valid    in   1       DrawX/DrawY valid this cycle
// DrawX        in   10      raster column
// DrawY        in   10      raster row
// SprX         in   10      sprite top-left column (live value)
// SprY         in   10      sprite top-left row (live value)
// flip         in   1       1 = mirror horizontally (live value)
// anim_go      in   1       request one playthrough of the animation
// rom_addr     out  ADDR_W  address to synchronous sprite ROM (1-cycle read latency)
// rom_data     in   4       ROM read data, valid 1 cycle after rom_addr
// pal_index    out  4       index to the palette stage
// hit          out  1       pixel inside sprite and pal_index != TRANSP_IDX
// out_valid    out  1       pal_index/hit correspond to a valid pixel
// anim_busy    out  1       animation FSM in PLAY
// anim_frame   out  log2(FRAMES)  current animation frame
// BEHAVIOUR
// - Reset (Reset_n=0 at an edge): rom_addr=0, pal_index=TRANSP_IDX, hit=0, out_valid=0,
//   anim_busy=0, anim_frame=0, tick counter=0, shadow SprX/SprY/flip=0. Applies mid-pipeline;
//   in-flight pixels are dropped.
// - Shadow regs: SprX/SprY/flip are copied into shadows only on edges with frame_start=1;
//   address math uses the shadows only. Live changes without frame_start have no effect.
// - Stage 0 (edge k): dx=DrawX-sSprX, dy=DrawY-sSprY, each computed 11-bit unsigned (a negative
//   result wraps large, so it counts as outside). inside=pix_valid & dx<SPR_W & dy<SPR_H.
//   lx = sflip ? SPR_W-1-dx : dx. rom_addr <= inside ? {anim_frame, dy[ly bits], lx} : 0.
//   inside_d1 and valid_d1 are registered alongside.
// - ROM (edge k+1): rom_data available; inside_d2 and valid_d2 are delayed to match.
// - Stage 2 (edge k+2): pal_index <= inside_d2 ? rom_data : TRANSP_IDX;
//   hit <= inside_d2 & (rom_data != TRANSP_IDX); out_valid <= valid_d2.
//   Total latency is 2 edges after the sample edge. The block is fully pipelined and accepts
//   one pixel every cycle; it has no backpressure.
// - Animation FSM:
//   - IDLE: anim_frame=0, anim_busy=0. anim_go -> PLAY, tick=0. If frame_start arrives in the
//     same cycle, that frame_start is not counted.
//   - PLAY: anim_busy=1. Each frame_start increments tick. When tick reaches FRAME_TICKS-1 and
//     frame_start=1: tick<=0 and anim_frame++. If anim_frame==FRAMES-1 at that moment, go to
//     IDLE with anim_frame<=0.
//   - anim_go during PLAY is ignored, including in the final-transition cycle.
//   - anim_frame therefore changes only on frame_start edges, i.e. never mid-frame.
// TESTING
// 1. Reset_n=0 for 3 edges with pix_valid=1, DrawX=SprX -> rom_addr=0, pal_index=0, hit=0,
//    out_valid=0, anim_frame=0.
// 2. SprX=100, SprY=50 latched by frame_start, flip=0; Draw(100,50) -> rom_addr=0;
//    Draw(163,113) -> rom_addr=4095. With rom_data=7, two edges later: hit=1, pal_index=7,
//    out_valid=1.
// 3. flip=1 latched; Draw(100,50) -> rom_addr=63; Draw(164,50) -> rom_addr=0, then hit=0 and
//    pal_index=0.
// 4. In-bounds pixel with rom_data=0 -> hit=0, pal_index=0, out_valid=1; pix_valid=0 ->
//    out_valid=0 two edges later.
// 5. anim_go, then 6 frame_starts -> anim_frame=1 and Draw(100,50) -> rom_addr=4096. After
//    24 frame_starts -> anim_busy=0, anim_frame=0. anim_go asserted mid-PLAY -> no restart.
// 6. SprX set to 200 with no frame_start -> addressing still uses 100. SprX=600 latched,
//    DrawX=10 -> outside, hit=0.

Source files
------------

// File: rtl/zfoblock_sprite_fetch.sv
// Sprite fetch stage: maps raster position to a sprite-ROM address (with flip and
// animation frame), then returns palette index and hit flag two edges after sampling.
module zfoblock_sprite_fetch #(
    parameter int         SPR_W       = 64,
    parameter int         SPR_H       = 64,
    parameter int         FRAMES      = 4,
    parameter int         ADDR_W      = 14,
    parameter int         FRAME_TICKS = 6,
    parameter logic [3:0] TRANSP_IDX  = 4'h0
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      frame_start,
    input  logic                      pix_valid,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic [9:0]                SprX,
    input  logic [9:0]                SprY,
    input  logic                      flip,
    input  logic                      anim_go,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [3:0]                rom_data,
    output logic [3:0]                pal_index,
    output logic                      hit,
    output logic                      out_valid,
    output logic                      anim_busy,
    output logic [$clog2(FRAMES)-1:0] anim_frame
);

    localparam int LX_W = $clog2(SPR_W);
    localparam int LY_W = $clog2(SPR_H);
    localparam int FR_W = $clog2(FRAMES);
    localparam int TK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    localparam logic [10:0]     SPR_W11   = 11'(SPR_W);
    localparam logic [10:0]     SPR_H11   = 11'(SPR_H);
    localparam logic [LX_W-1:0] LX_MAX    = LX_W'(SPR_W - 1);
    localparam logic [FR_W-1:0] FR_LAST   = FR_W'(FRAMES - 1);
    localparam logic [TK_W-1:0] TICK_LAST = TK_W'(FRAME_TICKS - 1);

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    state_t          r_state, w_state_nxt;
    logic [TK_W-1:0] r_tick, w_tick_nxt;
    logic [FR_W-1:0] r_frame, w_frame_nxt;

    logic [9:0]      r_spr_x, r_spr_y;
    logic            r_flip;

    logic [10:0]     w_dx, w_dy;
    logic [LX_W-1:0] w_lx;
    logic            w_inside;
    logic [ADDR_W-1:0] w_addr;

    logic            r_inside_p1, r_vld_p1;
    logic            r_inside_p2, r_vld_p2;

    // Shadow position/flip only move at frame_start so a sprite cannot tear mid-frame.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_spr_x <= '0;
            r_spr_y <= '0;
            r_flip  <= 1'b0;
        end else if (frame_start) begin
            r_spr_x <= SprX;
            r_spr_y <= SprY;
            r_flip  <= flip;
        end
    end

    // Stage 0: negative offsets wrap to large 11-bit values and fall outside the box.
    always_comb begin
        w_dx     = {1'b0, DrawX} - {1'b0, r_spr_x};
        w_dy     = {1'b0, DrawY} - {1'b0, r_spr_y};
        w_inside = pix_valid & (w_dx < SPR_W11) & (w_dy < SPR_H11);
        w_lx     = r_flip ? (LX_MAX - w_dx[LX_W-1:0]) : w_dx[LX_W-1:0];
        w_addr   = w_inside ? {r_frame, w_dy[LY_W-1:0], w_lx} : '0;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rom_addr    <= '0;
            r_inside_p1 <= 1'b0;
            r_vld_p1    <= 1'b0;
            r_inside_p2 <= 1'b0;
            r_vld_p2    <= 1'b0;
            pal_index   <= TRANSP_IDX;
            hit         <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            rom_addr    <= w_addr;
            r_inside_p1 <= w_inside;
            r_vld_p1    <= pix_valid;
            // Stage 1: ROM read in flight, control delayed to match.
            r_inside_p2 <= r_inside_p1;
            r_vld_p2    <= r_vld_p1;
            // Stage 2: ROM data captured into palette outputs.
            pal_index   <= r_inside_p2 ? rom_data : TRANSP_IDX;
            hit         <= r_inside_p2 & (rom_data != TRANSP_IDX);
            out_valid   <= r_vld_p2;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_frame <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    // A frame_start coinciding with anim_go in IDLE is deliberately not counted.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_frame_nxt = r_frame;
        case (r_state)
            S_IDLE: begin
                if (anim_go) begin
                    w_state_nxt = S_PLAY;
                    w_tick_nxt  = '0;
                    w_frame_nxt = '0;
                end
            end
            S_PLAY: begin
                if (frame_start) begin
                    if (r_tick == TICK_LAST) begin
                        w_tick_nxt = '0;
                        if (r_frame == FR_LAST) begin
                            w_state_nxt = S_IDLE;
                            w_frame_nxt = '0;
                        end else begin
                            w_frame_nxt = r_frame + 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        anim_busy  = (r_state == S_PLAY);
        anim_frame = r_frame;
    end

endmodule
